// File: rtl/sl3p_tx_sched.sv
`default_nettype none
// =============================================================================
// Module : sl3p_tx_sched
// Merges alignment markers, screened user data and idle fill into SL3 word-sets.
// Rev    : 1.0
// =============================================================================
module sl3p_tx_sched #(
   parameter int NUM_LN    = 4,
   parameter int AM_PERIOD = 2048,
   parameter int CNT_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic [NUM_LN*66-1:0] din,
   input  logic                 din_valid,
   output logic                 din_ready,
   output logic [NUM_LN*66-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   input  logic                 force_am,
   output logic                 am_sent,
   output logic                 idle_sent,
   output logic [NUM_LN-1:0]    hdr_err
);

   localparam int                  W           = 66;
   localparam logic [1:0]          c_hdr_ctl   = 2'b01;
   localparam logic [3:0]          c_type_idle = 4'b0000;
   localparam logic [3:0]          c_type_err  = 4'b0011;
   localparam logic [3:0]          c_type_am   = 4'b1100;
   localparam logic [CNT_BITS-1:0] c_cnt_one   = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] c_cnt_last  = CNT_BITS'(AM_PERIOD - 1);

   logic [NUM_LN*W-1:0] w_am_set;
   logic [NUM_LN*W-1:0] w_idle_set;
   logic [NUM_LN*W-1:0] w_scr_set;
   logic [NUM_LN-1:0]   w_bad;
   logic                w_slot;

   logic [NUM_LN*W-1:0] dout_q,       dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                am_due_q,     am_due_d;
   logic [CNT_BITS-1:0] am_cnt_q,     am_cnt_d;
   logic                am_sent_q,    am_sent_d;
   logic                idle_sent_q,  idle_sent_d;
   logic [NUM_LN-1:0]   hdr_err_q,    hdr_err_d;

   for (genvar i = 0; i < NUM_LN; i++) begin : g_lane
      logic [W-1:0] w_word;
      logic [3:0]   w_type;

      assign w_word = din[i*W +: W];
      assign w_type = w_word[37:34];

      // AM type has even parity, so it must be rejected explicitly
      assign w_bad[i] = (w_word[1:0] == 2'b00) || (w_word[1:0] == 2'b11) ||
                        ((w_word[1:0] == c_hdr_ctl) && ((^w_type) || (w_type == c_type_am)));

      assign w_am_set[i*W +: W]   = {24'd0, 4'(i % 16), c_type_am, 32'd0, c_hdr_ctl};
      assign w_idle_set[i*W +: W] = {28'd0, c_type_idle, 32'd0, c_hdr_ctl};
      assign w_scr_set[i*W +: W]  = w_bad[i] ? {28'd0, c_type_err, 32'd0, c_hdr_ctl} : w_word;
   end

   assign w_slot    = dout_ready || !dout_valid_q;
   assign din_ready = !srst && !am_due_q && w_slot;

   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      am_due_d     = am_due_q | force_am;
      am_cnt_d     = am_cnt_q;
      am_sent_d    = 1'b0;
      idle_sent_d  = 1'b0;
      hdr_err_d    = '0;
      if (w_slot) begin
         dout_valid_d = 1'b1;
         if (am_due_q) begin
            // a force_am landing on the AM slot re-arms for a back-to-back AM
            dout_d    = w_am_set;
            am_sent_d = 1'b1;
            am_cnt_d  = c_cnt_one;
            am_due_d  = force_am;
         end else begin
            if (am_cnt_q == c_cnt_last) begin
               am_due_d = 1'b1;
               am_cnt_d = '0;
            end else begin
               am_cnt_d = am_cnt_q + c_cnt_one;
            end
            if (din_valid) begin
               dout_d    = w_scr_set;
               hdr_err_d = w_bad;
            end else begin
               dout_d      = w_idle_set;
               idle_sent_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         dout_q       <= w_idle_set;
         dout_valid_q <= 1'b0;
         am_due_q     <= 1'b1;
         am_cnt_q     <= '0;
         am_sent_q    <= 1'b0;
         idle_sent_q  <= 1'b0;
         hdr_err_q    <= '0;
      end else begin
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         am_due_q     <= am_due_d;
         am_cnt_q     <= am_cnt_d;
         am_sent_q    <= am_sent_d;
         idle_sent_q  <= idle_sent_d;
         hdr_err_q    <= hdr_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign am_sent    = am_sent_q;
   assign idle_sent  = idle_sent_q;
   assign hdr_err    = hdr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sl3p_tx_sched.sv
`default_nettype none
// Bench for sl3p_tx_sched: randomized traffic against a word-stream reference
// model, plus directed reset, period, backpressure, screening and force_am cases.
module tb_sl3p_tx_sched;

   localparam int NL  = 4;
   localparam int W   = 66;
   localparam int SW  = NL * W;
   localparam int AMP = 8;

   logic          clk = 1'b0;
   logic          srst;
   logic [SW-1:0] din;
   logic          din_valid;
   logic          din_ready;
   logic [SW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          force_am;
   logic          am_sent;
   logic          idle_sent;
   logic [NL-1:0] hdr_err;

   always #5 clk = ~clk;

   sl3p_tx_sched #(.NUM_LN(NL), .AM_PERIOD(AMP), .CNT_BITS(16)) dut (
      .clk(clk), .srst(srst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .force_am(force_am),
      .am_sent(am_sent), .idle_sent(idle_sent), .hdr_err(hdr_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: what the link should carry, derived from the word rules
   logic [SW-1:0] m_dout;
   logic          m_valid;
   logic          m_due;
   logic          m_am;
   logic          m_idle;
   logic [NL-1:0] m_err;
   int            m_since;
   int            slot_idx;
   int            last_am_slot;
   bit            spacing_on;
   bit            auto_src;
   int            valid_pct;
   bit            last_xfer;

   task automatic chk_vec(string tag, logic [SW-1:0] got, logic [SW-1:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_w(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_ctrl(logic [3:0] typ, logic [3:0] lane_f);
      logic [W-1:0] w;
      w        = '0;
      w[1:0]   = 2'b01;
      w[37:34] = typ;
      w[41:38] = lane_f;
      return w;
   endfunction

   function automatic logic [SW-1:0] am_set();
      logic [SW-1:0] s;
      for (int i = 0; i < NL; i++) s[i*W +: W] = mk_ctrl(4'b1100, 4'(i));
      return s;
   endfunction

   function automatic logic [SW-1:0] idle_set();
      logic [SW-1:0] s;
      for (int i = 0; i < NL; i++) s[i*W +: W] = mk_ctrl(4'b0000, 4'h0);
      return s;
   endfunction

   function automatic logic lane_bad(logic [W-1:0] w);
      if (w[1:0] == 2'b00 || w[1:0] == 2'b11) return 1'b1;
      if (w[1:0] == 2'b01) begin
         if (w[37:34] == 4'b1100) return 1'b1;
         if (($countones(w[37:34]) % 2) == 1) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      logic [3:0]   t;
      int           k;
      w[31:0]  = $urandom;
      w[63:32] = $urandom;
      w[65:64] = 2'($urandom);
      t        = 4'($urandom);
      k        = int'($urandom_range(0, 9));
      if (k <= 5) begin
         w[1:0] = 2'b10;
      end else if (k == 6) begin
         if (($countones(t) % 2) == 1) t[0] = ~t[0];
         if (t == 4'b1100) t = 4'b0000;
         w[1:0]   = 2'b01;
         w[37:34] = t;
      end else if (k == 7) begin
         w[1:0] = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
      end else if (k == 8) begin
         if (($countones(t) % 2) == 0) t[0] = ~t[0];
         w[1:0]   = 2'b01;
         w[37:34] = t;
      end else begin
         w[1:0]   = 2'b01;
         w[37:34] = 4'b1100;
      end
      return w;
   endfunction

   task automatic new_src();
      din_valid = ($urandom_range(0, 99) < valid_pct);
      for (int i = 0; i < NL; i++) din[i*W +: W] = rand_word();
   endtask

   // one clock: predict, advance, compare, then present the next source word
   task automatic cycle();
      logic exp_rdy;
      logic issue;
      logic xfer;
      logic [W-1:0] w;
      #1;
      exp_rdy = !srst && !m_due && (dout_ready || !m_valid);
      chk_w("din_ready", 32'(din_ready), 32'(exp_rdy));
      issue = !srst && (dout_ready || !m_valid);
      xfer  = din_valid && exp_rdy;
      m_am   = 1'b0;
      m_idle = 1'b0;
      m_err  = '0;
      if (srst) begin
         m_valid      = 1'b0;
         m_dout       = idle_set();
         m_due        = 1'b1;
         m_since      = 0;
         last_am_slot = -1;
      end else if (issue) begin
         m_valid = 1'b1;
         slot_idx++;
         if (m_due) begin
            m_dout  = am_set();
            m_am    = 1'b1;
            m_due   = force_am;
            m_since = 0;
         end else begin
            m_since++;
            if (m_since == AMP - 1) m_due = 1'b1;
            if (force_am) m_due = 1'b1;
            if (din_valid) begin
               for (int i = 0; i < NL; i++) begin
                  w = din[i*W +: W];
                  if (lane_bad(w)) begin
                     m_dout[i*W +: W] = mk_ctrl(4'b0011, 4'h0);
                     m_err[i]         = 1'b1;
                  end else begin
                     m_dout[i*W +: W] = w;
                  end
               end
            end else begin
               m_dout = idle_set();
               m_idle = 1'b1;
            end
         end
      end else if (force_am) begin
         m_due = 1'b1;
      end
      @(posedge clk);
      #2;
      chk_w("dout_valid", 32'(dout_valid), 32'(m_valid));
      chk_vec("dout", dout, m_dout);
      chk_w("am_sent", 32'(am_sent), 32'(m_am));
      chk_w("idle_sent", 32'(idle_sent), 32'(m_idle));
      chk_w("hdr_err", 32'(hdr_err), 32'(m_err));
      if (am_sent) begin
         if (spacing_on && last_am_slot >= 0)
            chk_w("am_spacing", 32'(slot_idx - last_am_slot), 32'(AMP));
         last_am_slot = slot_idx;
      end
      last_xfer = xfer;
      if (auto_src && (xfer || !din_valid)) new_src();
      else if (!auto_src && xfer) din_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SW-1:0] scr;
      bit            got;
      m_dout       = idle_set();
      m_valid      = 1'b0;
      m_due        = 1'b1;
      m_since      = 0;
      slot_idx     = 0;
      last_am_slot = -1;
      spacing_on   = 1'b0;
      auto_src     = 1'b0;
      valid_pct    = 100;
      last_xfer    = 1'b0;
      srst         = 1'b1;
      din          = '0;
      din_valid    = 1'b0;
      dout_ready   = 1'b1;
      force_am     = 1'b0;

      // reset, then first slot must be an AM with lane indices
      repeat (3) cycle();
      chk_w("rst_valid", 32'(dout_valid), 32'(0));
      srst = 1'b0;
      cycle();
      chk_w("rst_am_sent", 32'(am_sent), 32'(1));
      for (int i = 0; i < NL; i++) chk_w("am_lane_idx", 32'(dout[i*W+38 +: 4]), 32'(i));
      cycle();
      chk_w("rst_idle_am", 32'(am_sent), 32'(0));
      chk_w("rst_idle", 32'(idle_sent), 32'(1));

      // steady data, constant ready
      auto_src   = 1'b1;
      valid_pct  = 100;
      spacing_on = 1'b1;
      new_src();
      repeat (40) cycle();

      // gearbox cadence backpressure
      for (int k = 0; k < 64; k++) begin
         dout_ready = (k % 2 == 0);
         cycle();
      end
      dout_ready = 1'b1;

      // directed screening word-set
      auto_src = 1'b0;
      scr = '0;
      scr[0*W +: W] = mk_ctrl(4'b0001, 4'h0);
      scr[1*W +: W] = mk_ctrl(4'b1100, 4'h5);
      scr[2*W +: W] = {64'h0123_4567_89AB_CDEF, 2'b11};
      scr[3*W +: W] = {64'hFEDC_BA98_7654_3210, 2'b10};
      din       = scr;
      din_valid = 1'b1;
      got       = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         cycle();
         if (last_xfer) got = 1'b1;
      end
      chk_w("scr_accepted", 32'(got), 32'(1));
      chk_w("scr_hdr_err", 32'(hdr_err), 32'h7);
      for (int i = 0; i < 3; i++) chk_vec("scr_err_lane", {198'd0, dout[i*W +: W]}, {198'd0, mk_ctrl(4'b0011, 4'h0)});
      chk_vec("scr_lane3", {198'd0, dout[3*W +: W]}, {198'd0, scr[3*W +: W]});

      // force_am at am_cnt=3, then periodic spacing resumes from the forced AM
      din_valid = 1'b0;
      got       = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         cycle();
         if (m_am) got = 1'b1;
      end
      chk_w("force_wait_am", 32'(got), 32'(1));
      repeat (2) cycle();
      force_am     = 1'b1;
      last_am_slot = -1;
      cycle();
      force_am = 1'b0;
      cycle();
      chk_w("force_am_next", 32'(am_sent), 32'(1));
      repeat (18) cycle();

      // force_am coincident with an AM issue gives back-to-back AMs
      spacing_on = 1'b0;
      got        = 1'b0;
      for (int k = 0; k < 20 && !m_due; k++) cycle();
      chk_w("b2b_due", 32'(m_due), 32'(1));
      force_am = 1'b1;
      cycle();
      force_am = 1'b0;
      chk_w("b2b_first", 32'(am_sent), 32'(1));
      cycle();
      chk_w("b2b_second", 32'(am_sent), 32'(1));

      // reset in the middle of traffic
      auto_src  = 1'b1;
      valid_pct = 100;
      new_src();
      repeat (5) cycle();
      srst = 1'b1;
      cycle();
      chk_w("mid_rst_valid", 32'(dout_valid), 32'(0));
      chk_w("mid_rst_ready", 32'(din_ready), 32'(0));
      srst = 1'b0;
      cycle();
      chk_w("mid_rst_am", 32'(am_sent), 32'(1));

      // random mix of ready, valid and force_am
      valid_pct = 70;
      for (int k = 0; k < 300; k++) begin
         dout_ready = ($urandom_range(0, 1) == 1);
         force_am   = ($urandom_range(0, 19) == 0);
         cycle();
      end
      force_am = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
